// File: rtl/base_edemux_stream_pkg.sv
// rtl/base_edemux_stream_pkg.sv - shared helpers for the encoded-destination stream demux
package base_edemux_stream_pkg;

  // First bit of channel k in a flattened ascending data bus of w bits per channel.
  function automatic int slice_base(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/base_edemux_slot.sv
// rtl/base_edemux_slot.sv - one-entry valid/ready holding register for a single demux channel
module base_edemux_slot #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [0:width-1] in_d,
  output logic             in_ready,
  output logic             out_v,
  input  logic             out_r,
  output logic [0:width-1] out_d
);

  // A full entry can still take a new beat when it drains on the same edge.
  assign in_ready = ~out_v | out_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (load) begin
      out_v <= 1'b1;
      out_d <= in_d;
    end else if (out_v && out_r) begin
      out_v <= 1'b0;
    end
  end

endmodule

// File: rtl/base_edemux_stream.sv
// rtl/base_edemux_stream.sv - routes one input stream to one of `ways` output channels by encoded select
module base_edemux_stream
  import base_edemux_stream_pkg::*;
#(
  parameter int width     = 1,
  parameter int ways      = 2,
  parameter int sel_width = $clog2(ways)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [0:sel_width-1]   i_sel,
  input  logic [0:width-1]       i_d,
  output logic [0:ways-1]        o_v,
  input  logic [0:ways-1]        o_r,
  output logic [0:width*ways-1]  o_d,
  output logic                   o_drop
);

  logic [0:ways-1] slot_ready;
  logic [0:ways-1] sel_hot;
  logic [0:ways-1] load;
  logic            in_range;
  logic            sel_ready;
  logic            accept;

  // Out-of-range selects decode to an all-zero one-hot and are always ready.
  always_comb begin
    sel_hot   = '0;
    in_range  = 1'b0;
    sel_ready = 1'b0;
    for (int k = 0; k < ways; k++) begin
      if (i_sel == sel_width'(k)) begin
        sel_hot[k] = 1'b1;
        in_range   = 1'b1;
        sel_ready  = slot_ready[k];
      end
    end
  end

  assign i_r    = reset_n & (~in_range | sel_ready);
  assign accept = i_v & i_r;
  assign load   = accept ? sel_hot : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_drop <= 1'b0;
    end else begin
      o_drop <= accept & ~in_range;
    end
  end

  for (genvar k = 0; k < ways; k++) begin : g_slot
    localparam int base = slice_base(k, width);
    base_edemux_slot #(
      .width(width)
    ) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load[k]),
      .in_d     (i_d),
      .in_ready (slot_ready[k]),
      .out_v    (o_v[k]),
      .out_r    (o_r[k]),
      .out_d    (o_d[base +: width])
    );
  end

endmodule

// File: tb/tb_base_edemux_stream.sv
// tb/tb_base_edemux_stream.sv - randomized and directed checks of base_edemux_stream against a queue model
module tb_base_edemux_stream;

  localparam int W = 8;
  localparam int N = 3;
  localparam int S = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_v;
  logic             i_r;
  logic [0:S-1]     i_sel;
  logic [0:W-1]     i_d;
  logic [0:N-1]     o_v;
  logic [0:N-1]     o_r;
  logic [0:W*N-1]   o_d;
  logic             o_drop;

  base_edemux_stream #(.width(W), .ways(N), .sel_width(S)) dut (
    .clk(clk), .reset_n(reset_n), .i_v(i_v), .i_r(i_r), .i_sel(i_sel), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: each channel is a FIFO of capacity one; last_d remembers the last value loaded.
  logic [7:0] q[N][$];
  logic [7:0] last_d[N];
  logic       exp_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst_n, input logic v, input logic [1:0] sel,
                      input logic [7:0] d, input logic [2:0] rdy);
    logic       exp_ir;
    logic       acc;
    logic [7:0] slice;
    @(negedge clk);
    reset_n = rst_n;
    i_v     = v;
    i_sel   = sel;
    i_d     = d;
    for (int k = 0; k < N; k++) o_r[k] = rdy[k];
    #1;
    exp_ir = rst_n && (sel >= N || q[sel].size() == 0 || rdy[sel]);
    check("i_r", {31'd0, i_r}, {31'd0, exp_ir});
    check("o_drop", {31'd0, o_drop}, {31'd0, exp_drop});
    for (int k = 0; k < N; k++) begin
      slice = o_d[k*W +: W];
      check($sformatf("o_v[%0d]", k), {31'd0, o_v[k]}, {31'd0, q[k].size() != 0});
      if (q[k].size() != 0) check($sformatf("o_d[%0d]", k), {24'd0, slice}, {24'd0, q[k][0]});
      else                  check($sformatf("o_d_hold[%0d]", k), {24'd0, slice}, {24'd0, last_d[k]});
    end
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        q[k].delete();
        last_d[k] = 8'h00;
      end
      exp_drop = 1'b0;
    end else begin
      acc = v && exp_ir;
      for (int k = 0; k < N; k++)
        if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
      if (acc && sel < N) begin
        q[sel].push_back(d);
        last_d[sel] = d;
      end
      exp_drop = acc && (sel >= N);
    end
  endtask

  initial begin
    reset_n = 1'b0; i_v = 1'b0; i_sel = '0; i_d = '0; o_r = '0;
    for (int k = 0; k < N; k++) last_d[k] = 8'h00;
    exp_drop = 1'b0;
    @(posedge clk);

    // Reset held two cycles with a beat offered, then release.
    step(1'b0, 1'b1, 2'd1, 8'h5A, 3'b111);
    step(1'b0, 1'b1, 2'd1, 8'h5A, 3'b111);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b111);

    // Single beat to channel 2 with every channel ready.
    step(1'b1, 1'b1, 2'd2, 8'hA5, 3'b111);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b111);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b111);

    // Channel 1 stalled: second beat blocked, channel 0 still flows, then ordered drain.
    step(1'b1, 1'b1, 2'd1, 8'h11, 3'b000);
    step(1'b1, 1'b1, 2'd1, 8'h22, 3'b000);
    step(1'b1, 1'b1, 2'd0, 8'h33, 3'b000);
    step(1'b1, 1'b1, 2'd1, 8'h22, 3'b000);
    step(1'b1, 1'b1, 2'd1, 8'h22, 3'b011);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b010);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b111);

    // Out-of-range select is accepted and dropped.
    step(1'b1, 1'b1, 2'd3, 8'h77, 3'b000);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b000);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b111);

    // Back-to-back beats to channel 0, then reset mid-stream.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2'd0, 8'(8'h40 + i), 3'b001);
    step(1'b0, 1'b1, 2'd0, 8'h99, 3'b001);
    step(1'b1, 1'b0, 2'd0, 8'h00, 3'b001);

    // Randomized traffic with occasional resets and stalls.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
